// File: rtl/ysyx_22040931_pipe_ctrl.sv
// Pipeline stall/flush/redirect sequencer: merges hazard and busy sources into one
// coherent set of per-stage hold/bubble controls plus a single PC redirect.
module ysyx_22040931_pipe_ctrl #(
    parameter int unsigned PC_W  = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             if_busy,
    input  logic             mem_busy,
    input  logic             ex_busy,
    input  logic             load_stall,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             fence_i,
    input  logic [PC_W-1:0]  id_pc,
    input  logic             pipe_empty,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             flush_mem_wb,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_REDIR_WAIT = 2'd1,
        S_DRAIN     = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Next state and zero-latency controls; everything is forced low while in reset.
    always_comb begin
        state_d        = state_q;
        pend_pc_d      = pend_pc_q;
        stall_pc       = 1'b0;
        stall_if_id    = 1'b0;
        stall_id_ex    = 1'b0;
        stall_ex_mem   = 1'b0;
        flush_if_id    = 1'b0;
        flush_id_ex    = 1'b0;
        flush_ex_mem   = 1'b0;
        flush_mem_wb   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        if (!reset) begin
            case (state_q)
                S_RUN: begin
                    if (mem_busy) begin
                        stall_pc     = 1'b1;
                        stall_if_id  = 1'b1;
                        stall_id_ex  = 1'b1;
                        stall_ex_mem = 1'b1;
                        flush_mem_wb = 1'b1;
                    end else if (ex_busy) begin
                        stall_pc     = 1'b1;
                        stall_if_id  = 1'b1;
                        stall_id_ex  = 1'b1;
                        flush_ex_mem = 1'b1;
                    end else if (load_stall) begin
                        stall_pc    = 1'b1;
                        stall_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end else if (branch_taken) begin
                        flush_if_id = 1'b1;
                        if (!if_busy) begin
                            redirect_valid = 1'b1;
                            redirect_pc    = branch_target;
                        end else begin
                            pend_pc_d = branch_target;
                            state_d   = S_REDIR_WAIT;
                        end
                    end else if (fence_i) begin
                        stall_pc    = 1'b1;
                        stall_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                        pend_pc_d   = id_pc + PC_W'(4);
                        state_d     = S_DRAIN;
                    end
                end

                S_REDIR_WAIT: begin
                    // IF/ID keeps taking bubbles so the stale fetch is discarded.
                    stall_pc    = 1'b1;
                    flush_if_id = 1'b1;
                    if (mem_busy) begin
                        stall_id_ex  = 1'b1;
                        stall_ex_mem = 1'b1;
                        flush_mem_wb = 1'b1;
                    end else if (ex_busy) begin
                        stall_id_ex  = 1'b1;
                        flush_ex_mem = 1'b1;
                    end
                    if (!if_busy) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = pend_pc_q;
                        state_d        = S_RUN;
                    end
                end

                S_DRAIN: begin
                    // A busy downstream stage holds ID/EX instead of bubbling it.
                    stall_pc = 1'b1;
                    if (mem_busy) begin
                        stall_id_ex  = 1'b1;
                        stall_ex_mem = 1'b1;
                        flush_mem_wb = 1'b1;
                    end else if (ex_busy) begin
                        stall_id_ex  = 1'b1;
                        flush_ex_mem = 1'b1;
                    end else begin
                        flush_id_ex = 1'b1;
                    end
                    if (pipe_empty && !if_busy) begin
                        flush_if_id    = 1'b1;
                        redirect_valid = 1'b1;
                        redirect_pc    = pend_pc_q;
                        state_d        = S_RUN;
                    end else begin
                        stall_if_id = 1'b1;
                    end
                end

                default: state_d = S_RUN;
            endcase
        end
    end

    // Saturating count of PC-hold cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_pc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_RUN;
            pend_pc_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
            cnt_q     <= cnt_d;
        end
    end

    assign stall_cycles = cnt_q;

endmodule
